mtc_ppa_gnt_decoder: RTL and testbench
======================================

# mtc_ppa_gnt_decoder

Converts one multi-grant bundle from the mTC-PPA priority encoder into a serial stream of granted requester indices, one per cycle, lowest index first. Sits downstream of the encoder's grant ready/valid port. Feeds per-requester consumers such as a mux select or a FIFO of granted IDs. Provides registered outputs and full back-pressure on both sides.

## Interface
- WIDTH_N, 10: requester vector width.
- AMOUNT_M, 2: number of grant slots per bundle.
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- gnt_i  input  [AMOUNT_M-1:0][WIDTH_N-1:0]  grant slot masks.
- gnt_vld_i  input  1  bundle valid.
- gnt_rdy_o  output  1  bundle accepted when high with gnt_vld_i.
- idx_o  output  IDX_W  granted requester index; IDX_W = max(1, $clog2(WIDTH_N)).
- idx_vld_o  output  1  index valid.
- idx_last_o  output  1  final index of the current bundle.
- idx_rdy_i  input  1  downstream ready.
- err_o  output  1  sticky bundle-format error.

## Operation
- Slot format: slot s is a step mask. Bit j is set iff at least AMOUNT_M-s requests exist at positions 0..j.
- Slot AMOUNT_M-1 carries the 1st grant, and slot 0 carries the AMOUNT_M-th grant.
- Decoded index of a slot is the position of its lowest set bit. A zero mask means the slot is empty.
- Non-empty slots are contiguous from AMOUNT_M-1 downward, so decode stops at the first empty slot.
- States:
  - IDLE: no index pending.
  - SEND: idx_vld_o=1.
- IDLE, on accept with slot AMOUNT_M-1 non-zero:
  - Store the bundle.
  - Load idx_o with ffs(slot AMOUNT_M-1).
  - Set idx_last_o = (AMOUNT_M==1) or (slot AMOUNT_M-2 is zero).
  - Set ptr = AMOUNT_M-2, then go to SEND.
- IDLE, on accept with slot AMOUNT_M-1 zero: the empty bundle is consumed, no index is emitted, and the block stays in IDLE.
- SEND, on handshake with idx_last_o=0:
  - Load idx_o with ffs(slot ptr).
  - Set idx_last_o = (ptr==0) or (slot ptr-1 is zero).
  - Decrement ptr.
- SEND, on handshake with idx_last_o=1:
  - Go to IDLE, unless a new bundle is accepted in the same cycle.
  - A new bundle accepted in that cycle is loaded as in IDLE.
- gnt_rdy_o = (state==IDLE) | (idx_vld_o & idx_last_o & idx_rdy_i). This is combinational from idx_rdy_i.

## Timing
- Reset values: idx_o=0, idx_vld_o=0, idx_last_o=0, err_o=0, state IDLE, ptr=0. gnt_rdy_o=1 after reset.
- Latency: bundle accepted at edge T gives the first index valid after edge T.
- A bundle with k non-empty slots occupies the output for exactly k handshake cycles when idx_rdy_i is held high.
- Back-to-back bundles produce no bubble.
- While idx_vld_o=1 and idx_rdy_i=0, idx_o and idx_last_o are held stable.
- Reset asserted mid-bundle discards the remaining indices. Outputs go to reset values immediately.
- gnt_i is sampled only on the accept cycle and need not be held after it.

## Configuration
- Macro: MTC_PPA_GNT_DEC_CHECK_EN.
- Defined: each accepted bundle is checked. err_o is set at the next edge if any of the following holds:
  - A slot is not a step mask (a 0 appears above a 1).
  - Slot nesting is violated: slot s-1 is not a subset of slot s.
  - A non-empty slot s-1 has the same lowest set bit as slot s.
- Defined: err_o clears only on reset. Decoding proceeds unchanged.
- Undefined: err_o is tied to 0 and no check logic is built.

## Structure
- Package mtc_ppa_pkg holds:
  - the IDX_W computation function;
  - the state enum (IDLE, SEND);
  - the step-mask check function.
- Sub-module mtc_ppa_ffs(WIDTH_N) is a combinational lowest-set-bit finder. Outputs: index and found.
- Two instances:
  - one on gnt_i slot AMOUNT_M-1, for the first load;
  - one on the stored slot ptr, muxed.

## Test plan
Configuration for all scenarios: WIDTH_N=10, AMOUNT_M=2, idx_rdy_i=1 unless stated.
- Two grants: slot1=0b1111111100, slot0=0b1111100000 -> idx 2 (last=0), then idx 5 (last=1), on cycles T+1 and T+2.
- One grant: slot1=0b1110000000, slot0=0 -> single idx 7 with last=1.
- Empty bundle: both slots 0 -> consumed, idx_vld_o stays 0, gnt_rdy_o stays 1.
- Back-pressure: scenario 1 with idx_rdy_i=0 for 3 cycles -> idx_o holds 2 and gnt_rdy_o=0. Then 2 and 5 are emitted in order.
- Back-to-back bundles, and reset: two-grant bundle followed immediately by the one-grant bundle -> 2, 5, 7 on consecutive cycles. Separately, reset_n low while idx 2 is pending -> all outputs 0 immediately, and no idx 5 after release.
- Format error, with MTC_PPA_GNT_DEC_CHECK_EN: slot1=0, slot0=0b0000000100 -> err_o=1 from T+1 until reset. Without the macro, err_o stays 0.

Source files
------------

// File: rtl/mtc_ppa_pkg.sv
// Shared types and helpers for the mTC-PPA grant decoder: index width, FSM states,
// step-mask check.
package mtc_ppa_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } dec_state_e;

    function automatic int idx_width(input int n);
        if (n <= 1) return 1;
        return $clog2(n);
    endfunction

    // A step mask never has a 0 directly above a 1 within the first w bits.
    function automatic logic is_step_mask(input logic [63:0] m, input int w);
        logic ok;
        ok = 1'b1;
        for (int j = 1; j < 64; j++) begin
            if (j < w && m[j-1] && !m[j]) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/mtc_ppa_ffs.sv
// Combinational lowest-set-bit finder.
module mtc_ppa_ffs
    import mtc_ppa_pkg::*;
#(
    parameter  int WIDTH_N = 10,
    localparam int IDX_W   = idx_width(WIDTH_N)
) (
    input  logic [WIDTH_N-1:0] mask,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int j = WIDTH_N - 1; j >= 0; j--) begin
            if (mask[j]) begin
                idx   = IDX_W'(j);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mtc_ppa_gnt_decoder.sv
// Serialises one mTC-PPA multi-grant bundle into granted indices, lowest first.
// Optional bundle-format checker enabled by MTC_PPA_GNT_DEC_CHECK_EN.
module mtc_ppa_gnt_decoder
    import mtc_ppa_pkg::*;
#(
    parameter  int WIDTH_N  = 10,
    parameter  int AMOUNT_M = 2,
    localparam int IDX_W    = idx_width(WIDTH_N)
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [AMOUNT_M-1:0][WIDTH_N-1:0] gnt_i,
    input  logic                             gnt_vld_i,
    output logic                             gnt_rdy_o,
    output logic [IDX_W-1:0]                 idx_o,
    output logic                             idx_vld_o,
    output logic                             idx_last_o,
    input  logic                             idx_rdy_i,
    output logic                             err_o
);

    localparam int PTR_W = idx_width(AMOUNT_M);
    localparam logic [PTR_W-1:0] PTR_INIT = PTR_W'((AMOUNT_M > 1) ? AMOUNT_M - 2 : 0);

    dec_state_e                       state, state_n;
    logic [PTR_W-1:0]                 ptr, ptr_n;
    logic [IDX_W-1:0]                 idx_n;
    logic                             last_n;
    logic [AMOUNT_M-1:0][WIDTH_N-1:0] gnt_q;

    logic                             accept, hs;
    logic [IDX_W-1:0]                 top_idx, sel_idx;
    logic                             top_found, sel_found;
    logic                             top_below_empty, sel_below_empty;
    logic [WIDTH_N-1:0]               sel_mask;

    assign idx_vld_o = (state == SEND);
    assign gnt_rdy_o = (state == IDLE) | (idx_vld_o & idx_last_o & idx_rdy_i);
    assign accept    = gnt_vld_i & gnt_rdy_o;
    assign hs        = idx_vld_o & idx_rdy_i;

    mtc_ppa_ffs #(.WIDTH_N(WIDTH_N)) u_ffs_top (
        .mask  (gnt_i[AMOUNT_M-1]),
        .idx   (top_idx),
        .found (top_found)
    );

    mtc_ppa_ffs #(.WIDTH_N(WIDTH_N)) u_ffs_sel (
        .mask  (sel_mask),
        .idx   (sel_idx),
        .found (sel_found)
    );

    // Slot selection by ptr, and whether the slot below the next one is empty.
    always_comb begin
        top_below_empty = (AMOUNT_M == 1);
        sel_mask        = '0;
        sel_below_empty = 1'b1;
        for (int s = 0; s < AMOUNT_M; s++) begin
            if (s == AMOUNT_M - 2)   top_below_empty = (gnt_i[s] == '0);
            if (s == int'(ptr))      sel_mask        = gnt_q[s];
            if (s + 1 == int'(ptr))  sel_below_empty = (gnt_q[s] == '0);
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        idx_n   = idx_o;
        last_n  = idx_last_o;
        case (state)
            IDLE: begin
                if (accept && top_found) begin
                    state_n = SEND;
                    idx_n   = top_idx;
                    last_n  = top_below_empty;
                    ptr_n   = PTR_INIT;
                end
            end
            SEND: begin
                if (hs) begin
                    if (!idx_last_o) begin
                        idx_n  = sel_found ? sel_idx : '0;
                        last_n = sel_below_empty;
                        ptr_n  = ptr - PTR_W'(1);
                    end else if (accept && top_found) begin
                        idx_n  = top_idx;
                        last_n = top_below_empty;
                        ptr_n  = PTR_INIT;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            ptr        <= '0;
            idx_o      <= '0;
            idx_last_o <= 1'b0;
        end else begin
            state      <= state_n;
            ptr        <= ptr_n;
            idx_o      <= idx_n;
            idx_last_o <= last_n;
        end
    end

    // Bundle storage is pure data; only the accept strobe qualifies it.
    always_ff @(posedge clk) begin
        if (accept) gnt_q <= gnt_i;
    end

`ifdef MTC_PPA_GNT_DEC_CHECK_EN
    logic fmt_bad;
    logic err_q;

    always_comb begin
        fmt_bad = 1'b0;
        for (int s = 0; s < AMOUNT_M; s++) begin
            if (!is_step_mask(64'(gnt_i[s]), WIDTH_N)) fmt_bad = 1'b1;
        end
        for (int s = 1; s < AMOUNT_M; s++) begin
            if ((gnt_i[s-1] & ~gnt_i[s]) != '0) fmt_bad = 1'b1;
            if (gnt_i[s-1] != '0 &&
                ((gnt_i[s-1] & (~gnt_i[s-1] + WIDTH_N'(1))) ==
                 (gnt_i[s]   & (~gnt_i[s]   + WIDTH_N'(1)))))
                fmt_bad = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) err_q <= 1'b0;
        else          err_q <= err_q | (accept & fmt_bad);
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mtc_ppa_gnt_decoder.sv
// Bench for mtc_ppa_gnt_decoder: directed scenarios plus randomized traffic
// against a queue-based model of the expected index stream.
module tb_mtc_ppa_gnt_decoder;

    localparam int N = 10;
    localparam int M = 2;

    typedef logic [M-1:0][N-1:0] bundle_t;
    typedef struct {
        int idx;
        bit last;
    } ent_t;

    logic       clk = 1'b0;
    logic       reset_n;
    bundle_t    gnt_i;
    logic       gnt_vld_i;
    logic       gnt_rdy_o;
    logic [3:0] idx_o;
    logic       idx_vld_o;
    logic       idx_last_o;
    logic       idx_rdy_i;
    logic       err_o;

    ent_t q[$];
    bit   err_m;
    int   n_pass = 0;
    int   n_tot  = 0;

    mtc_ppa_gnt_decoder #(.WIDTH_N(N), .AMOUNT_M(M)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .gnt_i      (gnt_i),
        .gnt_vld_i  (gnt_vld_i),
        .gnt_rdy_o  (gnt_rdy_o),
        .idx_o      (idx_o),
        .idx_vld_o  (idx_vld_o),
        .idx_last_o (idx_last_o),
        .idx_rdy_i  (idx_rdy_i),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    function automatic int lowbit(input logic [N-1:0] m);
        for (int j = 0; j < N; j++) if (m[j]) return j;
        return -1;
    endfunction

    // Build the slots a compliant encoder would produce for request vector r.
    function automatic bundle_t from_req(input logic [N-1:0] r);
        bundle_t g;
        int cnt;
        cnt = 0;
        for (int j = 0; j < N; j++) begin
            cnt += int'(r[j]);
            for (int s = 0; s < M; s++) g[s][j] = (cnt >= M - s);
        end
        return g;
    endfunction

    function automatic bit fmt_bad(input bundle_t g);
        bit bad;
        bad = 0;
        for (int s = 0; s < M; s++)
            for (int j = 1; j < N; j++)
                if (g[s][j-1] && !g[s][j]) bad = 1;
        for (int s = 1; s < M; s++) begin
            for (int j = 0; j < N; j++)
                if (g[s-1][j] && !g[s][j]) bad = 1;
            if (g[s-1] != '0 && lowbit(g[s-1]) == lowbit(g[s])) bad = 1;
        end
        return bad;
    endfunction

    // One clock: drive at negedge, predict the edge, compare at the next negedge.
    task automatic cycle(input bit v, input bundle_t g, input bit r);
        bit model_rdy;
        int added;
        gnt_vld_i = v;
        gnt_i     = g;
        idx_rdy_i = r;
        #1;
        model_rdy = (q.size() == 0) || (q.size() == 1 && r);
        chk("gnt_rdy", int'(gnt_rdy_o), int'(model_rdy));
        if (q.size() != 0 && r) void'(q.pop_front());
        if (v && model_rdy) begin
            added = 0;
            for (int s = M - 1; s >= 0; s--) begin
                if (g[s] == '0) break;
                q.push_back('{idx: lowbit(g[s]), last: 1'b0});
                added++;
            end
            if (added > 0) q[q.size()-1].last = 1'b1;
`ifdef MTC_PPA_GNT_DEC_CHECK_EN
            if (fmt_bad(g)) err_m = 1'b1;
`endif
        end
        @(negedge clk);
        chk("idx_vld", int'(idx_vld_o), int'(q.size() != 0));
        if (q.size() != 0) begin
            chk("idx", int'(idx_o), q[0].idx);
            chk("idx_last", int'(idx_last_o), int'(q[0].last));
        end
        chk("err", int'(err_o), int'(err_m));
    endtask

    bundle_t b1, b2, bz, be;

    initial begin
        b1 = '0; b1[1] = 10'b1111111100; b1[0] = 10'b1111100000;
        b2 = '0; b2[1] = 10'b1110000000;
        bz = '0;
        be = '0; be[0] = 10'b0000000100;
        err_m     = 1'b0;
        reset_n   = 1'b0;
        gnt_i     = '0;
        gnt_vld_i = 1'b0;
        idx_rdy_i = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_idx", int'(idx_o), 0);
        chk("rst_vld", int'(idx_vld_o), 0);
        chk("rst_last", int'(idx_last_o), 0);
        chk("rst_err", int'(err_o), 0);
        chk("rst_gnt_rdy", int'(gnt_rdy_o), 1);
        reset_n = 1'b1;

        // Model pins: the derived encoder format must match the hand example.
        chk("pin_from_req", int'(from_req(10'b0000100100) == b1), 1);
        chk("pin_fmt_ok", int'(fmt_bad(b1)), 0);
        chk("pin_fmt_bad", int'(fmt_bad(be)), 1);

        // Two grants
        cycle(1, b1, 1);
        chk("s1_idx0", int'(idx_o), 2); chk("s1_last0", int'(idx_last_o), 0);
        cycle(0, bz, 1);
        chk("s1_idx1", int'(idx_o), 5); chk("s1_last1", int'(idx_last_o), 1);
        cycle(0, bz, 1);
        chk("s1_done", int'(idx_vld_o), 0);

        // One grant
        cycle(1, b2, 1);
        chk("s2_idx", int'(idx_o), 7); chk("s2_last", int'(idx_last_o), 1);
        cycle(0, bz, 1);

        // Empty bundle
        cycle(1, bz, 1);
        chk("s3_vld", int'(idx_vld_o), 0); chk("s3_rdy", int'(gnt_rdy_o), 1);

        // Back-pressure
        cycle(1, b1, 0);
        for (int i = 0; i < 2; i++) begin
            cycle(0, bz, 0);
            chk("bp_hold", int'(idx_o), 2); chk("bp_rdy", int'(gnt_rdy_o), 0);
        end
        cycle(0, bz, 1);
        chk("bp_idx1", int'(idx_o), 5);
        cycle(0, bz, 1);

        // Back-to-back
        cycle(1, b1, 1); chk("b2b_0", int'(idx_o), 2);
        cycle(1, b2, 1); chk("b2b_1", int'(idx_o), 5);
        cycle(1, b2, 1); chk("b2b_2", int'(idx_o), 7); chk("b2b_vld", int'(idx_vld_o), 1);
        cycle(0, bz, 1);

        // Format error
        cycle(1, be, 1);
`ifdef MTC_PPA_GNT_DEC_CHECK_EN
        chk("err_set", int'(err_o), 1);
`else
        chk("err_off", int'(err_o), 0);
`endif
        cycle(0, bz, 1);

        // Reset mid-bundle
        cycle(1, b1, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("mrst_vld", int'(idx_vld_o), 0);
        chk("mrst_idx", int'(idx_o), 0);
        chk("mrst_last", int'(idx_last_o), 0);
        chk("mrst_err", int'(err_o), 0);
        q.delete();
        err_m     = 1'b0;
        gnt_vld_i = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        cycle(0, bz, 1);
        cycle(0, bz, 1);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            bundle_t g;
            int      kind;
            kind = int'($urandom_range(0, 19));
            if (kind < 17)       g = from_req(N'($urandom));
            else if (kind == 17) g = '0;
            else                 g = bundle_t'($urandom);
            cycle(($urandom_range(0, 9) < 7), g, ($urandom_range(0, 3) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
